// File: rtl/pwm_demodulator_pkg.sv
// Shared definitions for the PWM demodulator: FSM encodings and the default
// AM step/symbol timing constants that the TX modulator also uses.
package pwm_demodulator_pkg;

  typedef enum logic [0:0] {
    StHunt    = 1'b0,
    StMeasure = 1'b1
  } demod_state_e;

  localparam int unsigned AmClksPerStep    = 1;
  localparam int unsigned AmStepsPerSymbol = 128;
  localparam int unsigned AmSampleWidth    = 8;

endpackage

// File: rtl/module_counter.sv
// Free-running modulo counter: counts 0..max_count while en is high and pulses
// tc on the terminal count. clear forces the count back to zero.
module module_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] max_count,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = en && (count == max_count);

  // Count up and wrap at max_count; clear/reset restart from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_demodulator_edge_sync.sv
// 2-FF synchronizer for the asynchronous PWM pin plus a one-cycle-delayed copy
// and a rising-edge detect on the synchronized stream.
module pwm_demodulator_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic pwm_s,
  output logic pwm_d,
  output logic rise
);

  logic pwm_meta;

  // Synchronizer chain followed by the edge-detect delay stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_meta <= 1'b0;
      pwm_s    <= 1'b0;
      pwm_d    <= 1'b0;
    end else begin
      pwm_meta <= pwm_in;
      pwm_s    <= pwm_meta;
      pwm_d    <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;

endmodule

// File: rtl/pwm_demodulator.sv
// PWM demodulator: recovers one sample per PWM symbol by counting high steps
// and pushes it to a downstream FIFO through write/full.
// Optional build macro DEMOD_RESYNC_EN: a rising edge seen past mid-symbol
// closes the symbol early so RX timing follows TX clock drift.
module pwm_demodulator
  import pwm_demodulator_pkg::*;
#(
  parameter int unsigned CLKS_PER_PWM_STEP = AmClksPerStep,
  parameter int unsigned STEPS_PER_SYMBOL  = AmStepsPerSymbol,
  parameter int unsigned SAMPLE_WIDTH      = AmSampleWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    pwm_in,
  output logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    write,
  input  logic                    full,
  output logic                    locked,
  output logic                    overflow
);

  localparam logic [7:0] TickMax  = 8'(CLKS_PER_PWM_STEP - 1);
  localparam logic [7:0] LastStep = 8'(STEPS_PER_SYMBOL - 1);
  localparam logic [SAMPLE_WIDTH-1:0] HighMax = '1;
`ifdef DEMOD_RESYNC_EN
  localparam logic [7:0] HalfStep = 8'(STEPS_PER_SYMBOL / 2);
`endif

  logic                    pwm_s;
  logic                    pwm_d;
  logic                    rise;
  logic                    tick;
  logic                    tick_clear;
  demod_state_e            state;
  logic [7:0]              step_cnt;
  logic [SAMPLE_WIDTH-1:0] high_cnt;
  logic [SAMPLE_WIDTH-1:0] high_next;
  logic                    sym_end;
  logic                    resync_end;
  logic                    close;

  pwm_demodulator_edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .pwm_s  (pwm_s),
    .pwm_d  (pwm_d),
    .rise   (rise)
  );

  module_counter #(
    .WIDTH (8)
  ) u_step_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (tick_clear),
    .en        (enable),
    .max_count (TickMax),
    .tc        (tick)
  );

  // Step sampling uses pwm_d so that the rising-edge step itself is step 0 of
  // the symbol; the edge is only detected one cycle after pwm_s goes high.
  always_comb begin
    high_next = high_cnt;
    if (tick && pwm_d && (high_cnt != HighMax)) begin
      high_next = high_cnt + SAMPLE_WIDTH'(1);
    end
    sym_end = tick && (step_cnt == LastStep);
`ifdef DEMOD_RESYNC_EN
    resync_end = rise && (step_cnt >= HalfStep);
`else
    resync_end = 1'b0;
`endif
    close      = (state == StMeasure) && (sym_end || resync_end);
    tick_clear = !enable || (state == StHunt) || close;
  end

  // Hunt/measure FSM with registered sample, write, locked and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StHunt;
      step_cnt <= '0;
      high_cnt <= '0;
      sample   <= '0;
      write    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      write <= 1'b0;
      if (!enable) begin
        state    <= StHunt;
        step_cnt <= '0;
        high_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        unique case (state)
          StHunt: begin
            if (rise) begin
              state    <= StMeasure;
              step_cnt <= '0;
              high_cnt <= '0;
              locked   <= 1'b1;
            end
          end
          StMeasure: begin
            if (close) begin
              // Next symbol starts immediately; no dead cycle.
              step_cnt <= '0;
              high_cnt <= '0;
              if (full) begin
                overflow <= 1'b1;
              end else begin
                write  <= 1'b1;
                sample <= high_next;
              end
            end else if (tick) begin
              step_cnt <= step_cnt + 8'd1;
              high_cnt <= high_next;
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_demodulator.sv
// Scoreboard bench for pwm_demodulator (CLKS_PER_PWM_STEP=1, 128 steps/symbol).
module tb_pwm_demodulator;

  typedef struct {
    int val;
    int gap;  // required clocks since previous write; 0 = not checked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pwm_in;
  logic [7:0] sample;
  logic       write;
  logic       full;
  logic       locked;
  logic       overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_wr = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pwm_demodulator #(
    .CLKS_PER_PWM_STEP (1),
    .STEPS_PER_SYMBOL  (128),
    .SAMPLE_WIDTH      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .pwm_in   (pwm_in),
    .sample   (sample),
    .write    (write),
    .full     (full),
    .locked   (locked),
    .overflow (overflow)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every write pops the next expected sample (and optional spacing).
  always @(negedge clk) begin
    cyc++;
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got sample %0d expected no write", sample);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_sample", int'(sample), e.val);
        if (e.gap != 0) check("write_spacing", cyc - last_wr, e.gap);
      end
      last_wr = cyc;
    end
  end

  task automatic step(input logic v);
    pwm_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_part(input int duty, input int from, input int upto);
    for (int i = from; i < upto; i++) step(i < duty);
  endtask

  task automatic expect_wr(input int val, input int gap);
    exp_t e;
    e.val = val;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Let the last symbol's write land, then bounce enable to return to hunt.
  task automatic finish_test();
    repeat (16) step(1'b0);
    enable = 1'b0;
    repeat (3) step(1'b0);
    enable = 1'b1;
    repeat (3) step(1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    full   = 1'b0;
    repeat (3) step(1'b0);
    check("reset_sample", int'(sample), 0);
    check("reset_write", int'(write), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_overflow", int'(overflow), 0);
    rst    = 1'b0;
    enable = 1'b1;

    // Idle line never locks or writes.
    repeat (500) step(1'b0);
    check("idle_locked", int'(locked), 0);
    check("idle_sample", int'(sample), 0);
    check("idle_overflow", int'(overflow), 0);

    // Back-to-back symbols, exactly one symbol apart.
    expect_wr(64, 0);   send_part(64, 0, 128);
    expect_wr(1, 128);  send_part(1, 0, 128);
    expect_wr(127, 128); send_part(127, 0, 128);
    finish_test();

    // Duty 0 and 100% after lock.
    expect_wr(64, 0);  send_part(64, 0, 128);
    expect_wr(0, 128); send_part(0, 0, 128);
    check("lock_after_duty0", int'(locked), 1);
    expect_wr(128, 128); send_part(128, 0, 128);
    check("lock_after_duty128", int'(locked), 1);
    finish_test();

    // FIFO full across one symbol end drops that sample.
    expect_wr(10, 0); send_part(10, 0, 128);
    send_part(20, 0, 64);
    full = 1'b1;
    send_part(20, 64, 128);
    send_part(30, 0, 64);
    full = 1'b0;
    check("overflow_set", int'(overflow), 1);
    expect_wr(30, 256);
    send_part(30, 64, 128);
    finish_test();
    check("overflow_sticky", int'(overflow), 1);

    // Enable low mid-symbol discards the partial symbol, then relock.
    expect_wr(50, 0); send_part(50, 0, 128);
    send_part(70, 0, 60);
    enable = 1'b0;
    send_part(70, 60, 64);
    enable = 1'b1;
    send_part(70, 64, 100);
    check("hunt_after_enable", int'(locked), 0);
    send_part(70, 100, 128);
    expect_wr(33, 0); send_part(33, 0, 128);
    finish_test();
    check("overflow_kept", int'(overflow), 1);

    // TX symbol period of 126 steps, duty 40.
`ifdef DEMOD_RESYNC_EN
    expect_wr(40, 0);
    expect_wr(40, 126);
    expect_wr(40, 126);
`else
    expect_wr(42, 0);
    expect_wr(42, 128);
    expect_wr(36, 128);
`endif
    for (int s = 0; s < 3; s++) send_part(40, 0, 126);
    finish_test();

    // Reset mid-symbol: everything cleared, no write from the partial symbol.
    send_part(80, 0, 100);
    rst = 1'b1;
    step(1'b0);
    check("rst_write", int'(write), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_sample", int'(sample), 0);
    rst = 1'b0;
    repeat (200) step(1'b0);

    check("pending_writes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
